// File: rtl/inst_mem_loader_if.sv
// Byte-stream ingress and instruction-memory write bus of the boot loader.
// Ports: in_valid/in_data/in_ready (byte stream), wr_en/wr_addr/wr_data.
interface inst_mem_loader_if #(
   parameter int ADDR_W = 16
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   modport master (
      output in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot loader: big-endian byte stream (count, then words) into imem writes.
// Ports: clk, rst (async active-low), start, bus (stream + write bus),
//        cpu_hold, done, error, words_loaded.
module inst_mem_loader #(
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                TIMEOUT   = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   inst_mem_loader_if.slave   bus,
   output logic               cpu_hold,
   output logic               done,
   output logic               error,
   output logic [15:0]        words_loaded
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_HI,
      S_CNT_LO,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t            st;
   state_t            nxt;
   logic [TW-1:0]     tcnt;
   logic [15:0]       cnt_n;
   logic [15:0]       wcnt;
   logic [15:0]       wcnt_inc;
   logic [1:0]        idx;
   logic [23:0]       asm_q;
   logic [31:0]       wdata;
   logic [ADDR_W-1:0] waddr;
   logic              rdy;
   logic              acc;
   logic              tmo;
   logic              sess;

   assign rdy = (st == S_CNT_HI) | (st == S_CNT_LO) | (st == S_DATA);
   assign acc = rdy & bus.in_valid;
   // An accepted byte beats an expiring idle counter.
   assign tmo = rdy & ~acc & (tcnt == TO_LAST);
   assign sess = start & ((st == S_IDLE) | (st == S_DONE) | (st == S_ERR));
   assign wcnt_inc = wcnt + 16'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st <= S_IDLE;
      else      st <= nxt;
   end

   always_comb begin
      nxt = st;
      unique case (st)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) nxt = S_CNT_HI;
         end
         S_CNT_HI: begin
            if (acc)      nxt = S_CNT_LO;
            else if (tmo) nxt = S_ERR;
         end
         S_CNT_LO: begin
            if (acc) begin
               if ({cnt_n[15:8], bus.in_data} == 16'd0) nxt = S_DONE;
               else                                    nxt = S_DATA;
            end else if (tmo) begin
               nxt = S_ERR;
            end
         end
         S_DATA: begin
            if (acc && idx == 2'd3) nxt = S_WRITE;
            else if (tmo)           nxt = S_ERR;
         end
         S_WRITE: begin
            if (wcnt_inc == cnt_n) nxt = S_DONE;
            else                   nxt = S_DATA;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt  <= '0;
         cnt_n <= '0;
         wcnt  <= '0;
         idx   <= '0;
         asm_q <= '0;
         wdata <= '0;
         waddr <= BASE_ADDR;
      end else begin
         // Idle counter only runs while waiting on the stream.
         if (nxt != st || acc || !rdy) tcnt <= '0;
         else                          tcnt <= tcnt + TW'(1);

         if (sess) begin
            wcnt  <= '0;
            idx   <= '0;
            waddr <= BASE_ADDR;
         end

         if (acc) begin
            unique case (st)
               S_CNT_HI: cnt_n[15:8] <= bus.in_data;
               S_CNT_LO: begin
                  cnt_n[7:0] <= bus.in_data;
                  idx        <= '0;
               end
               S_DATA: begin
                  asm_q <= {asm_q[15:0], bus.in_data};
                  idx   <= idx + 2'd1;
                  if (idx == 2'd3) wdata <= {asm_q, bus.in_data};
               end
               default: ;
            endcase
         end

         if (st == S_WRITE) begin
            wcnt  <= wcnt_inc;
            waddr <= waddr + ADDR_W'(1);
         end
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.wr_en     = (st == S_WRITE);
   assign bus.wr_addr   = waddr;
   assign bus.wr_data   = wdata;
   assign cpu_hold      = (st != S_DONE);
   assign done          = (st == S_DONE);
   assign error         = (st == S_ERR);
   assign words_loaded  = wcnt;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: two instances (base 0 and base 0xFFFF)
// share one byte stream and are checked against a write-list model.
module tb_inst_mem_loader;

   typedef struct {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        valid = 1'b0;
   logic [7:0]  data = 8'h00;
   logic        hold0, done0, err0;
   logic        hold1, done1, err1;
   logic [15:0] wl0, wl1;

   int cmp = 0;
   int bad = 0;
   int rdy_bad = 0;
   wr_t cap0[$];
   wr_t cap1[$];
   logic [31:0] wl[$];

   inst_mem_loader_if #(.ADDR_W(16)) b0 ();
   inst_mem_loader_if #(.ADDR_W(16)) b1 ();

   assign b0.in_valid = valid;
   assign b0.in_data  = data;
   assign b1.in_valid = valid;
   assign b1.in_data  = data;

   inst_mem_loader #(
      .ADDR_W(16), .BASE_ADDR(16'h0000), .TIMEOUT(10)
   ) d0 (
      .clk(clk), .rst(rst), .start(start), .bus(b0.slave),
      .cpu_hold(hold0), .done(done0), .error(err0),
      .words_loaded(wl0)
   );

   inst_mem_loader #(
      .ADDR_W(16), .BASE_ADDR(16'hFFFF), .TIMEOUT(10)
   ) d1 (
      .clk(clk), .rst(rst), .start(start), .bus(b1.slave),
      .cpu_hold(hold1), .done(done1), .error(err1),
      .words_loaded(wl1)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (b0.wr_en) cap0.push_back('{b0.wr_addr, b0.wr_data});
      if (b1.wr_en) cap1.push_back('{b1.wr_addr, b1.wr_data});
      if (b0.wr_en && b0.in_ready) rdy_bad++;
      if (b1.wr_en && b1.in_ready) rdy_bad++;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_rdy0", {31'd0, b0.in_ready}, 0);
      chk("rst_wen0", {31'd0, b0.wr_en}, 0);
      chk("rst_addr0", {16'd0, b0.wr_addr}, 32'h0000);
      chk("rst_addr1", {16'd0, b1.wr_addr}, 32'hFFFF);
      chk("rst_data0", b0.wr_data, 0);
      chk("rst_hold0", {31'd0, hold0}, 1);
      chk("rst_done0", {31'd0, done0}, 0);
      chk("rst_err0", {31'd0, err0}, 0);
      chk("rst_words0", {16'd0, wl0}, 0);
      chk("rst_words1", {16'd0, wl1}, 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Present one byte after 'gap' idle cycles; returns at the negedge
   // following the edge that accepted it.
   task automatic send(input logic [7:0] b, input int gap, input bit st);
      bit ok;
      bit got;
      got = 1'b0;
      valid = 1'b0;
      repeat (gap) @(negedge clk);
      valid = 1'b1;
      data  = b;
      start = st;
      for (int t = 0; t < 30; t++) begin
         ok = b0.in_ready;
         @(negedge clk);
         start = 1'b0;
         if (ok) begin
            got = 1'b1;
            break;
         end
      end
      valid = 1'b0;
      chk("accept", {31'd0, got}, 1);
   endtask

   task automatic check_writes(input int n);
      wr_t e;
      chk("nwr0", cap0.size(), n);
      chk("nwr1", cap1.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < cap0.size()) begin
            e.a = 16'(i);
            chk("wr_addr0", {16'd0, cap0[i].a}, {16'd0, e.a});
            chk("wr_data0", cap0[i].d, wl[i]);
         end
         if (i < cap1.size()) begin
            e.a = 16'(32'hFFFF + i);
            chk("wr_addr1", {16'd0, cap1[i].a}, {16'd0, e.a});
            chk("wr_data1", cap1[i].d, wl[i]);
         end
      end
   endtask

   task automatic load(input int gmin, input int gmax, input bit inj);
      logic [15:0] nn;
      logic [31:0] w;
      int n;
      n = wl.size();
      nn = 16'(n);
      cap0.delete();
      cap1.delete();
      pulse_start();
      send(nn[15:8], $urandom_range(gmax, gmin), 1'b0);
      send(nn[7:0], $urandom_range(gmax, gmin), 1'b0);
      for (int i = 0; i < n; i++) begin
         w = wl[i];
         for (int k = 0; k < 4; k++) begin
            send(w[31 - 8*k -: 8], $urandom_range(gmax, gmin),
                 inj && (k == 1));
         end
         chk("wen_lat", {31'd0, b0.wr_en}, 1);
         chk("rdy_in_write", {31'd0, b0.in_ready}, 0);
         if (inj) pulse_start();
      end
      repeat (2) @(negedge clk);
      chk("done0", {31'd0, done0}, 1);
      chk("done1", {31'd0, done1}, 1);
      chk("hold0", {31'd0, hold0}, 0);
      chk("err0", {31'd0, err0}, 0);
      chk("words0", {16'd0, wl0}, n);
      chk("words1", {16'd0, wl1}, n);
      check_writes(n);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_reset();
      rst = 1'b1;
      @(negedge clk);
      chk("idle_rdy", {31'd0, b0.in_ready}, 0);

      // Directed two-word image, stream held valid.
      wl = '{32'hDEADBEEF, 32'h12345678};
      load(0, 0, 1'b0);
      chk("wrap_addr", {16'd0, cap1.size() > 1 ? cap1[1].a : 16'hDEAD}, 0);

      // Empty image.
      cap0.delete();
      cap1.delete();
      pulse_start();
      chk("cnt_hold", {31'd0, hold0}, 1);
      chk("cnt_done", {31'd0, done0}, 0);
      send(8'h00, 0, 1'b0);
      send(8'h00, 0, 1'b0);
      chk("n0_done", {31'd0, done0}, 1);
      chk("n0_hold", {31'd0, hold0}, 0);
      chk("n0_words", {16'd0, wl0}, 0);
      repeat (3) @(negedge clk);
      chk("n0_nwr", cap0.size(), 0);

      // Same random image, gap-free then gappy.
      wl = '{$urandom, $urandom, $urandom};
      load(0, 0, 1'b0);
      load(0, 8, 1'b0);

      // Every byte arrives exactly as the idle counter expires.
      wl = '{$urandom};
      load(9, 9, 1'b0);

      // Idle timeout after the first data byte.
      cap0.delete();
      cap1.delete();
      pulse_start();
      send(8'h00, 0, 1'b0);
      send(8'h01, 0, 1'b0);
      send(8'hAA, 0, 1'b0);
      repeat (9) @(negedge clk);
      chk("to_early", {31'd0, err0}, 0);
      @(negedge clk);
      chk("to_err0", {31'd0, err0}, 1);
      chk("to_err1", {31'd0, err1}, 1);
      chk("to_hold", {31'd0, hold0}, 1);
      chk("to_rdy", {31'd0, b0.in_ready}, 0);
      chk("to_nwr", cap0.size(), 0);
      wl = '{$urandom, $urandom};
      load(0, 3, 1'b0);

      // Reset in the middle of the second word.
      cap0.delete();
      cap1.delete();
      pulse_start();
      send(8'h00, 0, 1'b0);
      send(8'h02, 0, 1'b0);
      for (int i = 0; i < 5; i++) send(8'(i + 1), 0, 1'b0);
      #2 rst = 1'b0;
      #1 chk_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      wl = '{$urandom, $urandom};
      load(0, 2, 1'b0);

      // Start pulses during DATA and WRITE are ignored.
      wl = '{$urandom, $urandom, $urandom, $urandom};
      load(0, 1, 1'b1);

      chk("rdy_during_write", rdy_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Boot loader that writes a program image into the instruction memory, which the CPU core then fetches from at PC = BASE_ADDR upward. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and issues one word-addressed write per word. While loading, it holds the CPU in reset so the core never fetches a partially written image.

Parameters:
ADDR_W, 16, instruction-memory word-address width (matches 16-bit PC, word addressed, PC+1 per instruction)
BASE_ADDR, 0, word address of first written instruction
TIMEOUT, 1000, max idle cycles between accepted bytes while loading before abort (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse, begins a load session
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader can accept a byte this cycle
wr_en  output  1  instruction-memory write strobe, one cycle per word
wr_addr  output  ADDR_W  instruction-memory word address
wr_data  output  32  instruction word
cpu_hold  output  1  high = keep CPU in reset / PC frozen
done  output  1  level, image loaded successfully
error  output  1  level, session aborted by timeout
words_loaded  output  16  count of words written in current/last session

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, error=0, words_loaded=0, timeout counter=0.
- Byte accepted iff in_valid & in_ready on a rising edge. in_data is ignored otherwise.
- Stream format: CNT_HI byte, CNT_LO byte (16-bit word count N, big-endian), then 4*N bytes, each word MSB first.
- States and transitions:
  IDLE: in_ready=0; start -> CNT_HI; clear words_loaded, done, error; load wr_addr=BASE_ADDR.
  CNT_HI: in_ready=1; accept -> store N[15:8], go to CNT_LO.
  CNT_LO: in_ready=1; accept -> store N[7:0]; if N==0 -> DONE, else DATA with byte index 0.
  DATA: in_ready=1; each accept shifts the byte into the word assembler (first byte -> [31:24]). The 4th accept -> WRITE.
  WRITE: in_ready=0; wr_en=1 for exactly this cycle, wr_data=assembled word, wr_addr=current address. Next cycle: words_loaded+1, wr_addr+1. If words_loaded+1==N -> DONE, else DATA.
  DONE: done=1, cpu_hold=0, in_ready=0; start -> CNT_HI (new session, done cleared, cpu_hold=1).
  ERR: error=1, cpu_hold=1, in_ready=0; start -> CNT_HI (new session, error cleared).
- cpu_hold=1 in every state except DONE. It deasserts the cycle DONE is entered.
- wr_en=1 only in WRITE. wr_addr/wr_data hold their values outside WRITE.
- Address arithmetic is modulo 2^ADDR_W. BASE_ADDR+N overflow wraps to 0 silently.
- Timeout: in CNT_HI/CNT_LO/DATA the counter increments each cycle with no accepted byte and clears on accept. When it reaches TIMEOUT -> ERR. A byte accepted in the same cycle as the counter reaching TIMEOUT wins: the byte is accepted and the counter clears. The counter clears on entering any state.
- start while in CNT_HI/CNT_LO/DATA/WRITE is ignored.
- Reset mid-session: immediate return to IDLE per reset values. Partially written memory contents are not rolled back.
- Latency: 4th data byte accepted at edge k -> wr_en high during cycle k+1. After the last write, done=1 at cycle k+2.

Test Plan:
- Load N=2 (bytes 00 02 DE AD BE EF 12 34 56 78), in_valid held high, BASE_ADDR=0 -> wr_en pulses with (0,0xDEADBEEF) and (1,0x12345678); in_ready=0 during WRITE cycles; done=1, cpu_hold=0, words_loaded=2.
- N=0 (bytes 00 00) -> no wr_en; DONE entered after CNT_LO; cpu_hold falls; words_loaded=0.
- Gappy stream: in_valid toggles randomly, gaps < TIMEOUT, N=3 -> identical writes to the gap-free run; no error.
- Timeout: TIMEOUT=10, send 00 01 AA then idle 10 cycles -> error=1, cpu_hold=1, no wr_en. A following start plus a valid stream loads correctly and clears error.
- Reset mid-load: rst=0 after 5 data bytes of N=2 -> outputs return to reset values immediately. A restarted load writes from BASE_ADDR.
- start pulses during DATA and WRITE -> ignored; session completes normally. BASE_ADDR=0xFFFF, N=2 -> writes to 0xFFFF, then 0x0000.
